crc_serial_engine: RTL and testbench

//  Parametrised bit-serial CRC generator/checker. Successor to the fixed 8-bit, one-bit-per-clock CRC-8/MAXIM shifter.

---
 rtl/crc_pkg.sv | 21 ++
 rtl/crc_step.sv | 17 +
 rtl/crc_serial_engine.sv | 125 ++++++++++++
 tb/tb_crc_serial_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and helpers for the bit-serial CRC engine: FSM state encoding,
// bit reversal and common polynomial presets.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]  CRC8_MAXIM_POLY  = 8'h31;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  // Reverses the low `width` bits of value; bits above width come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = value[31-i];
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/crc_step.sv
// One-bit CRC update: shifts the register left once and folds in POLY when the
// outgoing MSB differs from the incoming data bit.
module crc_step #(
  parameter int          W    = 8,
  parameter logic [31:0] POLY = 32'h31
) (
  input  logic [W-1:0] i_crc,
  input  logic         i_bit,
  output logic [W-1:0] o_crc_next
);

  logic w_fb;

  assign w_fb       = i_crc[W-1] ^ i_bit;
  assign o_crc_next = {i_crc[W-2:0], 1'b0} ^ (w_fb ? POLY[W-1:0] : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Parametrised bit-serial CRC generator/checker with valid/ready word input.
// Define CRC_CHECK_EN to add the crc_ok residue-compare output.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int          W         = 8,
  parameter logic [31:0] POLY      = 32'(CRC8_MAXIM_POLY),
  parameter logic [31:0] INIT      = 32'h0,
  parameter logic [31:0] XOROUT    = 32'h0,
  parameter int          DW        = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          REFOUT    = 1'b1,
  parameter logic [31:0] RESIDUE   = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [W-1:0]  crc_out,
  output logic          crc_valid,
  output logic          busy
`ifdef CRC_CHECK_EN
  ,
  output logic          crc_ok
`endif
);

  localparam int             BCW      = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

  state_t         r_state, w_state_next;
  logic [DW-1:0]  r_buf;
  logic           r_last;
  logic [BCW-1:0] r_bitcnt;
  logic [W-1:0]   r_crc, w_crc_next, w_result;
  logic           w_bit, w_done;

  // The shift buffer is shifted toward the tap, so the next bit is always at a fixed end.
  assign w_bit    = LSB_FIRST ? r_buf[0] : r_buf[DW-1];
  assign w_done   = (r_state == DONE) && !clear;
  assign w_result = (REFOUT ? W'(bit_reverse(32'(r_crc), W)) : r_crc) ^ XOROUT[W-1:0];

  crc_step #(.W(W), .POLY(POLY)) u_step (
    .i_crc      (r_crc),
    .i_bit      (w_bit),
    .o_crc_next (w_crc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_next = SHIFT;
        SHIFT:   if (r_bitcnt == LAST_BIT) w_state_next = r_last ? DONE : IDLE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf    <= '0;
      r_last   <= 1'b0;
      r_bitcnt <= '0;
      r_crc    <= INIT[W-1:0];
    end else if (clear) begin
      r_buf    <= '0;
      r_last   <= 1'b0;
      r_bitcnt <= '0;
      r_crc    <= INIT[W-1:0];
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_buf    <= in_data;
          r_last   <= in_last;
          r_bitcnt <= '0;
        end
        SHIFT: begin
          r_crc    <= w_crc_next;
          r_bitcnt <= r_bitcnt + 1'b1;
          r_buf    <= LSB_FIRST ? (r_buf >> 1) : (r_buf << 1);
        end
        DONE:    r_crc <= INIT[W-1:0];
        default: ;
      endcase
    end
  end

  // crc_out is held across clear; only a completed frame replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_out   <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= w_done;
      if (w_done) crc_out <= w_result;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_ok <= 1'b0;
    else     crc_ok <= w_done && (r_crc == RESIDUE[W-1:0]);
  end
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench: CRC-8/MAXIM and CRC-16/CCITT-FALSE instances share one stimulus
// stream; expected results come from a byte-oriented reference model.
module tb_crc_serial_engine;

  typedef logic [7:0] byte_q[$];
  typedef struct {
    logic [31:0] crc;
    bit          ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready8, in_ready16, busy8, busy16, v8, v16;
  logic [7:0]  out8;
  logic [15:0] out16;
`ifdef CRC_CHECK_EN
  logic        ok8, ok16;
`endif

  int compared = 0, mismatched = 0;
  int cyc = 0;
  int last_accept_cyc = 0, valid_cyc8 = 0;
  int rdy_cnt = 0;
  bit count_en = 1'b0;
  bit prev_v8 = 1'b0, prev_v16 = 1'b0;
  exp_t q8[$], q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_engine u_dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .crc_out(out8), .crc_valid(v8), .busy(busy8)
`ifdef CRC_CHECK_EN
    , .crc_ok(ok8)
`endif
  );

  crc_serial_engine #(
    .W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOROUT(32'h0), .DW(8),
    .LSB_FIRST(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0)
  ) u_dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .crc_out(out16), .crc_valid(v16), .busy(busy16)
`ifdef CRC_CHECK_EN
    , .crc_ok(ok16)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  // Raw (unreflected, pre-XOROUT) register after the whole message.
  function automatic logic [31:0] model_raw(input byte_q msg, input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bit refin);
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    logic [31:0] r, rp;
    if (refin) begin
      r  = rev(init & mask, w);
      rp = rev(poly & mask, w);
      foreach (msg[k]) begin
        r ^= {24'h0, msg[k]};
        repeat (8) r = r[0] ? ((r >> 1) ^ rp) : (r >> 1);
      end
      return rev(r, w);
    end
    r = init & mask;
    foreach (msg[k]) begin
      r ^= ({24'h0, msg[k]} << (w - 8));
      repeat (8) r = (r[w-1] ? ((r << 1) ^ poly) : (r << 1)) & mask;
    end
    return r;
  endfunction

  function automatic exp_t exp8(input byte_q msg);
    logic [31:0] raw = model_raw(msg, 8, 32'h31, 32'h0, 1'b1);
    exp_t e;
    e.crc = rev(raw, 8);
    e.ok  = (raw == 0);
    return e;
  endfunction

  function automatic exp_t exp16(input byte_q msg);
    logic [31:0] raw = model_raw(msg, 16, 32'h1021, 32'hFFFF, 1'b0);
    exp_t e;
    e.crc = raw;
    e.ok  = (raw == 0);
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (count_en && in_ready8) rdy_cnt++;
    if (v8) begin
      valid_cyc8 = cyc;
      check("valid8_not_consecutive", prev_v8, 0);
      check("busy8_at_valid", busy8, 0);
      if (q8.size() == 0) fail_now("unexpected crc_valid on 8-bit engine");
      else begin
        e = q8.pop_front();
        check("crc8_out", out8, e.crc);
`ifdef CRC_CHECK_EN
        check("crc8_ok", ok8, e.ok);
`endif
      end
    end
    if (v16) begin
      check("valid16_not_consecutive", prev_v16, 0);
      if (q16.size() == 0) fail_now("unexpected crc_valid on 16-bit engine");
      else begin
        e = q16.pop_front();
        check("crc16_out", out16, e.crc);
`ifdef CRC_CHECK_EN
        check("crc16_ok", ok16, e.ok);
`endif
      end
    end
    prev_v8  = v8;
    prev_v16 = v16;
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [7:0] d, input bit last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready8) fail_now("in_ready timeout");
    @(posedge clk);
    #1 last_accept_cyc = cyc;
  endtask

  task automatic send_frame(input byte_q msg, input exp_t e8, input exp_t e16, input int gap_max);
    for (int i = 0; i < msg.size(); i++) begin
      if (i == msg.size() - 1) begin
        q8.push_back(e8);
        q16.push_back(e16);
      end
      send_word(msg[i], i == msg.size() - 1);
      if (gap_max > 0 && $urandom_range(1, 0) == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0) fail_now("crc_valid timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q check_msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    byte_q msg;
    exp_t  e8, e16;
    int    first_acc;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_crc_out", out8, 0);
    check("reset_crc_valid", v8, 0);
    check("reset_busy", busy8, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready8, 1);

    // Known-answer check values for both presets.
    e8 = '{crc: 32'hA1, ok: 1'b0};
    e16 = '{crc: 32'h29B1, ok: 1'b0};
    send_frame(check_msg, e8, e16, 0);
    wait_drain();
    check("busy_low_after_frame", busy8, 0);

    // Single zero word: latency from accept to strobe is DW+1.
    msg = '{8'h00};
    e8  = '{crc: 32'h00, ok: 1'b1};
    send_frame(msg, e8, exp16(msg), 0);
    first_acc = last_accept_cyc;
    wait_drain();
    check("single_word_latency", valid_cyc8 - first_acc, 9);

    // in_valid held high across the whole frame.
    #1 count_en = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < check_msg.size(); i++) begin
      if (i == check_msg.size() - 1) begin
        q8.push_back('{crc: 32'hA1, ok: 1'b0});
        q16.push_back('{crc: 32'h29B1, ok: 1'b0});
      end
      send_word(check_msg[i], i == check_msg.size() - 1);
      if (i == 0) first_acc = last_accept_cyc;
    end
    check("held_valid_accept_span", last_accept_cyc - first_acc, 72);
    @(negedge clk);
    in_valid = 1'b0;
    count_en = 1'b0;
    check("held_valid_ready_cycles", rdy_cnt, 9);
    wait_drain();

    // Abort mid-shift of the fifth word; nothing may be reported for it.
    for (int i = 0; i < 5; i++) send_word(check_msg[i], 1'b0);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clear_returns_idle", busy8, 0);
    check("clear_keeps_crc_out", out8, 8'hA1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_blocks_accept", busy8, 0);
    repeat (12) @(negedge clk);
    e8  = '{crc: 32'hA1, ok: 1'b0};
    e16 = '{crc: 32'h29B1, ok: 1'b0};
    send_frame(check_msg, e8, e16, 0);
    wait_drain();

    // Asynchronous reset in the middle of a frame.
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_crc_out8", out8, 0);
    check("rst_mid_crc_out16", out16, 0);
    check("rst_mid_valid", v8, 0);
    check("rst_mid_busy", busy8, 0);
    check("rst_mid_in_ready", in_ready8, 1);
    repeat (12) @(negedge clk);

    // Receive path: data followed by the transmitted CRC leaves a zero residue.
    msg = check_msg;
    msg.push_back(8'hA1);
    send_frame(msg, '{crc: 32'h00, ok: 1'b1}, exp16(msg), 0);
    wait_drain();
    msg = check_msg;
    msg.push_back(8'hA0);
    e8 = exp8(msg);
    e8.ok = 1'b0;
    send_frame(msg, e8, exp16(msg), 0);
    wait_drain();

    // Randomised frames with random gaps.
    for (int f = 0; f < 30; f++) begin
      msg = {};
      repeat ($urandom_range(6, 1)) msg.push_back(8'($urandom));
      if (f % 5 == 0) begin
        e8 = exp8(msg);
        msg.push_back(8'(e8.crc));
      end
      send_frame(msg, exp8(msg), exp16(msg), 3);
    end
    wait_drain();
    check("scoreboard8_empty", q8.size(), 0);
    check("scoreboard16_empty", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
